dct_vec_rot: RTL and testbench
==============================

# dct_vec_rot

Streaming post-rotation stage of the FFT-based DCT. It consumes FFT bins F(k), k=1..N, in natural order. Using cos/sin coefficients from `dct_vecRot_coeff`, it produces the real DCT output D(k) = round((Re F(k)·cos_k + Im F(k)·sin_k) / 65536). The block sits between the FFT core output and the DCT output formatter. It drives the coefficient generator's `sink_valid` and `fftpts_in` so that the coefficient address stays locked to the sample index.

## Interface
- wDataIn, 16, signed width of sink_real / sink_imag
- wCoeff, 18, signed width of coefficients (Q16, 65536 = 1.0)
- wDataOut, 18, signed width of source_real
- COEFF_LAT, 1, clocks from coeff_req high to the matching coeff_cos/coeff_sin
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- sink_valid  in  1  input sample valid
- sink_sop  in  1  first bin of frame (k=1)
- sink_eop  in  1  last bin of frame (k=N)
- sink_real  in  wDataIn  Re F(k)
- sink_imag  in  wDataIn  Im F(k)
- fftpts_in  in  12  N; legal values 32,64,128,256,512,1024,2048
- coeff_req  out  1  drives coefficient generator sink_valid
- coeff_fftpts  out  12  N latched at sop; drives generator fftpts_in
- coeff_cos  in  wCoeff  cos coefficient, COEFF_LAT after coeff_req
- coeff_sin  in  wCoeff  sin coefficient, COEFF_LAT after coeff_req
- source_valid  out  1  output valid
- source_sop  out  1  first output of frame
- source_eop  out  1  last output of frame
- source_real  out  wDataOut  D(k)
- source_error  out  1  one-cycle protocol error pulse

## Operation
- FSM states: IDLE, RUN.
- IDLE → RUN: on sink_valid & sink_sop with legal fftpts_in. At the same time, latch N into coeff_fftpts and set cnt=1.
- sink_valid & sink_sop with illegal fftpts_in: source_error pulses, the frame is ignored, and the FSM stays in IDLE.
- In RUN, each sink_valid cycle increments cnt.
- RUN → IDLE when cnt==N is accepted. source_eop is generated from the counter and is never passed through from sink_eop.
- In IDLE, sink_valid without sop is ignored: no coeff_req and no output.
- coeff_req = sink_valid & (RUN | starting a legal frame). It is combinational, so the generator sees its address-0 cycle on the sop sample.
- Error conditions. Each one pulses source_error one cycle after detection.
  - sink_valid low while in RUN: the frame is aborted and the FSM goes to IDLE. The generator's address resets because coeff_req drops.
  - sink_sop while in RUN: the old frame is aborted without emitting eop. The new frame starts in the same cycle.
  - sink_eop with cnt≠N: error only; counting continues.
  - cnt==N without sink_eop: error only; the frame closes normally.
- Samples already accepted before an abort still emerge from the pipeline. No source_eop is emitted for an aborted frame.
- Arithmetic:
  - Products p_r = sink_real·cos and p_i = sink_imag·sin, each a full signed wDataIn+wCoeff bits.
  - Sum s = p_r + p_i, one extra bit.
  - Round: s + 2^15, then arithmetic shift right by 16.
  - Saturate to the signed wDataOut range [−2^(wDataOut−1), 2^(wDataOut−1)−1].

## Timing
- Reset values: coeff_req=0, coeff_fftpts=0, source_valid=0, source_sop=0, source_eop=0, source_real=0, source_error=0, FSM=IDLE, cnt=0, pipeline valids=0.
- Input data and sop/eop flags are delayed by COEFF_LAT registers so they align with the coefficients.
- Pipeline stages after alignment:
  - +1: product registers
  - +2: sum and rounding register
  - +3: shift, saturation and output register
- Total latency from sink cycle to source cycle: L = COEFF_LAT + 3 (4 by default).
- Back-to-back frames are supported with no idle cycle: sop may arrive the cycle after the eop sample.
- There is no backpressure; output is one sample per input sample.
- source_error is registered and independent of the data pipe.
- Reset asserted mid-frame clears everything immediately. The first frame after release needs a new sop.

## Test plan
- N=32 frame, sink_real=1000, sink_imag=0 for all k, coeff_cos=65536, coeff_sin=0 → 32 outputs of 1000; source_sop at first output, source_eop at the 32nd; first output 4 cycles after the sop input.
- Rounding: real=3, imag=0, cos=32768 → s=98304, output 2. real=−3, cos=32768 → output −1. real=1, cos=32767 → output 0.
- Saturation with wDataOut=16: real=imag=32767, cos=sin=65536 → source_real=32767. real=imag=−32768 → −32768.
- Mid-frame valid drop at k=10 of N=64 → source_error pulses once; 10 outputs with sop and no eop; a new sop frame of 64 then completes normally with eop.
- sop at k=20 of N=128, then a full 256-point frame → error pulse; old frame emits 19 samples without eop; new frame emits 256 samples with sop/eop and coeff_fftpts=256.
- fftpts_in=100 at sop → error pulse; coeff_req stays 0 and no source_valid for that frame.

Source files
------------

// File: rtl/dct_vec_rot_if.sv
// Bus bundle for the DCT post-rotation stage: FFT bin input, coefficient
// generator handshake and DCT output.
interface dct_vec_rot_if #(
  parameter int wDataIn  = 16,
  parameter int wCoeff   = 18,
  parameter int wDataOut = 18
);
  logic                        sink_valid;
  logic                        sink_sop;
  logic                        sink_eop;
  logic signed [wDataIn-1:0]   sink_real;
  logic signed [wDataIn-1:0]   sink_imag;
  logic        [11:0]          fftpts_in;
  logic                        coeff_req;
  logic        [11:0]          coeff_fftpts;
  logic signed [wCoeff-1:0]    coeff_cos;
  logic signed [wCoeff-1:0]    coeff_sin;
  logic                        source_valid;
  logic                        source_sop;
  logic                        source_eop;
  logic signed [wDataOut-1:0]  source_real;
  logic                        source_error;

  modport master (
    output sink_valid, sink_sop, sink_eop, sink_real, sink_imag, fftpts_in,
    output coeff_cos, coeff_sin,
    input  coeff_req, coeff_fftpts,
    input  source_valid, source_sop, source_eop, source_real, source_error
  );

  modport slave (
    input  sink_valid, sink_sop, sink_eop, sink_real, sink_imag, fftpts_in,
    input  coeff_cos, coeff_sin,
    output coeff_req, coeff_fftpts,
    output source_valid, source_sop, source_eop, source_real, source_error
  );
endinterface

// File: rtl/dct_vec_rot.sv
// Streaming DCT post-rotation: D(k) = round((Re F(k)*cos + Im F(k)*sin) / 2^16),
// with frame tracking that keeps the coefficient generator locked to the bin index.
module dct_vec_rot #(
  parameter int wDataIn   = 16,
  parameter int wCoeff    = 18,
  parameter int wDataOut  = 18,
  parameter int COEFF_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  dct_vec_rot_if.slave  bus
);
  localparam int PW = wDataIn + wCoeff;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] RND  = SW'(32'sd32768);
  localparam logic signed [SW-1:0] OMAX = {{(SW-wDataOut+1){1'b0}}, {(wDataOut-1){1'b1}}};
  localparam logic signed [SW-1:0] OMIN = {{(SW-wDataOut+1){1'b1}}, {(wDataOut-1){1'b0}}};

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  function automatic logic is_legal(input logic [11:0] n);
    case (n)
      12'd32, 12'd64, 12'd128, 12'd256, 12'd512, 12'd1024, 12'd2048: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  endfunction

  state_t              state_q;
  logic [11:0]         cnt_q, fftpts_q;
  logic                err_d, err_q;
  logic                legal_s, run_s, start_s, acc_s, last_s, knext_hit_s;
  logic [11:0]         k_next_s;

  logic [COEFF_LAT-1:0]       dv_q, dsop_q, deop_q;
  logic signed [wDataIn-1:0]  dre_q [COEFF_LAT];
  logic signed [wDataIn-1:0]  dim_q [COEFF_LAT];
  logic                       v1_q, sop1_q, eop1_q, v2_q, sop2_q, eop2_q;
  logic signed [PW-1:0]       pr_q, pi_q;
  logic signed [SW-1:0]       sum_q, shifted_s;
  logic                       src_valid_q, src_sop_q, src_eop_q;
  logic signed [wDataOut-1:0] src_real_q;

  assign legal_s     = is_legal(bus.fftpts_in);
  assign run_s       = (state_q == S_RUN);
  assign start_s     = bus.sink_valid & bus.sink_sop & legal_s;
  assign k_next_s    = cnt_q + 12'd1;
  assign knext_hit_s = (k_next_s == fftpts_q);
  // A sop sample either starts a legal frame or is rejected, whatever the state.
  assign acc_s       = bus.sink_valid & (bus.sink_sop ? legal_s : run_s);
  assign last_s      = run_s & bus.sink_valid & ~bus.sink_sop & knext_hit_s;

  always_comb begin
    err_d = 1'b0;
    if (bus.sink_valid & bus.sink_sop) begin
      err_d = ~legal_s | run_s | bus.sink_eop;
    end else if (run_s) begin
      err_d = ~bus.sink_valid | (bus.sink_eop ^ knext_hit_s);
    end else begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 12'd0;
      fftpts_q <= 12'd0;
      err_q    <= 1'b0;
    end else begin
      err_q <= err_d;
      if (bus.sink_valid & bus.sink_sop) begin
        state_q  <= legal_s ? S_RUN : S_IDLE;
        cnt_q    <= legal_s ? 12'd1 : 12'd0;
        fftpts_q <= legal_s ? bus.fftpts_in : fftpts_q;
      end else if (run_s & (~bus.sink_valid | last_s)) begin
        state_q <= S_IDLE;
        cnt_q   <= 12'd0;
      end else if (run_s) begin
        cnt_q <= k_next_s;
      end
    end
  end

  // Delay the accepted sample and its frame flags to meet the coefficients.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_q   <= '0;
      dsop_q <= '0;
      deop_q <= '0;
      for (int i = 0; i < COEFF_LAT; i++) begin
        dre_q[i] <= '0;
        dim_q[i] <= '0;
      end
    end else begin
      dv_q[0]   <= acc_s;
      dsop_q[0] <= start_s;
      deop_q[0] <= last_s;
      dre_q[0]  <= bus.sink_real;
      dim_q[0]  <= bus.sink_imag;
      for (int i = 1; i < COEFF_LAT; i++) begin
        dv_q[i]   <= dv_q[i-1];
        dsop_q[i] <= dsop_q[i-1];
        deop_q[i] <= deop_q[i-1];
        dre_q[i]  <= dre_q[i-1];
        dim_q[i]  <= dim_q[i-1];
      end
    end
  end

  assign shifted_s = sum_q >>> 16;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {v1_q, sop1_q, eop1_q, v2_q, sop2_q, eop2_q} <= '0;
      pr_q        <= '0;
      pi_q        <= '0;
      sum_q       <= '0;
      src_valid_q <= 1'b0;
      src_sop_q   <= 1'b0;
      src_eop_q   <= 1'b0;
      src_real_q  <= '0;
    end else begin
      v1_q   <= dv_q[COEFF_LAT-1];
      sop1_q <= dsop_q[COEFF_LAT-1];
      eop1_q <= deop_q[COEFF_LAT-1];
      pr_q   <= PW'(dre_q[COEFF_LAT-1]) * PW'(bus.coeff_cos);
      pi_q   <= PW'(dim_q[COEFF_LAT-1]) * PW'(bus.coeff_sin);
      v2_q   <= v1_q;
      sop2_q <= sop1_q;
      eop2_q <= eop1_q;
      sum_q  <= SW'(pr_q) + SW'(pi_q) + RND;
      src_valid_q <= v2_q;
      src_sop_q   <= sop2_q;
      src_eop_q   <= eop2_q;
      if (shifted_s > OMAX) begin
        src_real_q <= OMAX[wDataOut-1:0];
      end else if (shifted_s < OMIN) begin
        src_real_q <= OMIN[wDataOut-1:0];
      end else begin
        src_real_q <= shifted_s[wDataOut-1:0];
      end
    end
  end

  assign bus.coeff_req    = acc_s;
  assign bus.coeff_fftpts = fftpts_q;
  assign bus.source_valid = src_valid_q;
  assign bus.source_sop   = src_sop_q;
  assign bus.source_eop   = src_eop_q;
  assign bus.source_real  = src_real_q;
  assign bus.source_error = err_q;
endmodule

// File: tb/tb_dct_vec_rot.sv
// Directed + randomized bench for dct_vec_rot; the bench also plays the
// coefficient generator (coefficients appear one cycle after the sample).
module tb_dct_vec_rot;
  localparam int OUTW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dct_vec_rot_if #(.wDataIn(16), .wCoeff(18), .wDataOut(OUTW)) dif ();

  dct_vec_rot #(.wDataIn(16), .wCoeff(18), .wDataOut(OUTW), .COEFF_LAT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif.slave)
  );

  int checks = 0;
  int errors = 0;
  int c = 0;
  bit exp_v [8192];
  bit exp_s [8192];
  bit exp_e [8192];
  bit exp_err [8192];
  int exp_d [8192];
  int pend_cos = 0, pend_sin = 0;
  bit in_frame = 1'b0;
  int k = 0, nn = 0;

  function automatic int ref_d(input int re, im, cs, sn);
    longint s;
    s = longint'(re) * longint'(cs) + longint'(im) * longint'(sn) + 64'sd32768;
    s = s >>> 16;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  function automatic bit legal_n(input int n);
    return (n == 32 || n == 64 || n == 128 || n == 256 || n == 512 || n == 1024 || n == 2048);
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, c, obs, expv);
    end
  endtask

  // One bus cycle: check what is due now, drive the sample, predict its effects.
  task automatic step(input bit v, s, e, input int re, im, cs, sn, n);
    bit acc, osop, oeop, err;
    @(negedge clk);
    c++;
    chk("source_valid", dif.source_valid, exp_v[c]);
    chk("source_error", dif.source_error, exp_err[c]);
    if (exp_v[c]) begin
      chk("source_sop", dif.source_sop, exp_s[c]);
      chk("source_eop", dif.source_eop, exp_e[c]);
      chk("source_real", dif.source_real, exp_d[c]);
    end
    dif.sink_valid = v;
    dif.sink_sop   = s;
    dif.sink_eop   = e;
    dif.sink_real  = 16'(re);
    dif.sink_imag  = 16'(im);
    dif.fftpts_in  = 12'(n);
    dif.coeff_cos  = 18'(pend_cos);
    dif.coeff_sin  = 18'(pend_sin);
    pend_cos = cs;
    pend_sin = sn;
    acc = 0; osop = 0; oeop = 0; err = 0;
    if (v && s) begin
      if (legal_n(n)) begin
        err = in_frame || e;
        in_frame = 1; nn = n; k = 1;
        acc = 1; osop = 1;
      end else begin
        err = 1; in_frame = 0;
      end
    end else if (v && in_frame) begin
      k++;
      acc = 1;
      oeop = (k == nn);
      err = (e != (k == nn));
      if (k == nn) in_frame = 0;
    end else if (!v && in_frame) begin
      err = 1; in_frame = 0;
    end
    exp_v[c+4] = acc;
    exp_s[c+4] = osop;
    exp_e[c+4] = oeop;
    exp_d[c+4] = ref_d(re, im, cs, sn);
    exp_err[c+1] = err;
    #1;
    chk("coeff_req", dif.coeff_req, acc);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0, 0, 0, 32);
  endtask

  function automatic int rnd16();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  function automatic int rndc();
    return int'($urandom_range(131072)) - 65536;
  endfunction

  // Frame of len samples for size n; eop flagged on sample n. rnd selects random data.
  task automatic frame(input int n, len, input bit rnd, input int re, im, cs, sn);
    for (int i = 1; i <= len; i++) begin
      if (rnd) step(1, i == 1, i == n, rnd16(), rnd16(), rndc(), rndc(), n);
      else     step(1, i == 1, i == n, re, im, cs, sn, n);
    end
  endtask

  initial begin
    dif.sink_valid = 0; dif.sink_sop = 0; dif.sink_eop = 0;
    dif.sink_real = '0; dif.sink_imag = '0; dif.fftpts_in = 12'd32;
    dif.coeff_cos = '0; dif.coeff_sin = '0;
    #3;
    chk("reset source_valid", dif.source_valid, 0);
    chk("reset source_sop", dif.source_sop, 0);
    chk("reset source_eop", dif.source_eop, 0);
    chk("reset source_real", dif.source_real, 0);
    chk("reset source_error", dif.source_error, 0);
    chk("reset coeff_fftpts", dif.coeff_fftpts, 0);
    chk("reset coeff_req", dif.coeff_req, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    idle(2);
    frame(32, 32, 0, 1000, 0, 65536, 0);
    idle(2);

    // Rounding and saturation corners at the head of a 32-point frame.
    step(1, 1, 0, 3, 0, 32768, 0, 32);
    step(1, 0, 0, -3, 0, 32768, 0, 32);
    step(1, 0, 0, 1, 0, 32767, 0, 32);
    step(1, 0, 0, 32767, 32767, 65536, 65536, 32);
    step(1, 0, 0, -32768, -32768, 65536, 65536, 32);
    for (int i = 6; i <= 32; i++) step(1, 0, i == 32, rnd16(), rnd16(), rndc(), rndc(), 32);
    idle(3);

    // Valid in IDLE without sop must be ignored.
    step(1, 0, 0, 5, 5, 65536, 0, 64);
    step(1, 0, 1, 5, 5, 65536, 0, 64);
    idle(2);

    // Valid drop at k=10 of 64, then a complete 64 frame.
    frame(64, 10, 1, 0, 0, 0, 0);
    idle(3);
    frame(64, 64, 1, 0, 0, 0, 0);

    // Back-to-back: sop at k=20 of 128 restarts as 256.
    frame(128, 19, 1, 0, 0, 0, 0);
    frame(256, 256, 1, 0, 0, 0, 0);
    #1;
    chk("coeff_fftpts", dif.coeff_fftpts, 256);
    idle(2);

    // Illegal size: error, frame ignored.
    step(1, 1, 0, 100, 100, 65536, 0, 100);
    for (int i = 0; i < 5; i++) step(1, 0, 0, rnd16(), rnd16(), rndc(), rndc(), 100);
    idle(2);

    // eop early and missing eop.
    for (int i = 1; i <= 32; i++) step(1, i == 1, i == 7, rnd16(), rnd16(), rndc(), rndc(), 32);
    frame(32, 32, 1, 0, 0, 0, 0);
    frame(128, 128, 1, 0, 0, 0, 0);
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
